// File: rtl/kyber_pkg.sv
// Kyber arithmetic constants and the signed coefficient type
// shared by the inverse-NTT butterfly datapath.
package kyber_pkg;
  localparam int KYBER_Q   = 3329;
  localparam int QINV      = -3327;
  localparam int BARRETT_V = 20159;
  localparam int DATA_W    = 16;

  typedef logic signed [DATA_W-1:0] coef_t;
endpackage

// File: rtl/gs_butterfly_if.sv
// Valid/ready streaming bundle for the GS butterfly:
// input pair + twiddle on one side, result pair on the other.
interface gs_butterfly_if;
  import kyber_pkg::*;

  logic  in_valid;
  logic  in_ready;
  coef_t in_a;
  coef_t in_b;
  coef_t in_zeta;
  logic  out_valid;
  logic  out_ready;
  coef_t out_a;
  coef_t out_b;

  modport slave (
    input  in_valid, in_a, in_b, in_zeta,
    input  out_ready,
    output in_ready,
    output out_valid, out_a, out_b
  );

  modport master (
    output in_valid, in_a, in_b, in_zeta,
    output out_ready,
    input  in_ready,
    input  out_valid, out_a, out_b
  );
endinterface

// File: rtl/barrett_reduce.sv
// Combinational Barrett reduction of a signed 16-bit value
// to a centred representative modulo q.
module barrett_reduce
  import kyber_pkg::*;
(
  input  coef_t i_x,
  output coef_t o_r
);

  int w_t;

  assign w_t = (BARRETT_V * int'(i_x) + (1 <<< 25)) >>> 26;
  assign o_r = coef_t'(int'(i_x) - w_t * KYBER_Q);

endmodule

// File: rtl/gs_butterfly.sv
// Three-stage Gentleman-Sande butterfly for the Kyber inverse NTT:
// out_a = barrett(a + b), out_b = fqmul(zeta, b - a).
module gs_butterfly
  import kyber_pkg::*;
(
  input  logic           clk,
  input  logic           rst_n,
  gs_butterfly_if.slave  bus
);

  logic r1_v;
  logic r2_v;
  logic r3_v;

  coef_t r1_sum;
  coef_t r1_diff;
  coef_t r1_zeta;
  coef_t r2_bar;
  coef_t r3_a;
  coef_t r3_b;

  logic signed [31:0] r2_prod;

  logic w_s3_free;
  logic w_s2_free;
  logic w_s1_free;
  logic w_in_fire;

  coef_t w_bar;
  coef_t w_m;
  coef_t w_mont;

  logic signed [31:0] w_mt;

  // Ready ripples back through the stages so a full pipe still streams
  assign w_s3_free = !r3_v || bus.out_ready;
  assign w_s2_free = !r2_v || w_s3_free;
  assign w_s1_free = !r1_v || w_s2_free;
  assign w_in_fire = bus.in_valid && w_s1_free;

  assign bus.in_ready  = w_s1_free;
  assign bus.out_valid = r3_v;
  assign bus.out_a     = r3_a;
  assign bus.out_b     = r3_b;

  barrett_reduce u_barrett (
    .i_x (r1_sum),
    .o_r (w_bar)
  );

  // Montgomery: low half of prod*QINV, then the exact high half
  assign w_m    = coef_t'(r2_prod * QINV);
  assign w_mt   = r2_prod - int'(w_m) * KYBER_Q;
  assign w_mont = w_mt[31:16];

  always_ff @(posedge clk) begin
    if (w_in_fire) begin
      r1_sum  <= bus.in_a + bus.in_b;
      r1_diff <= bus.in_b - bus.in_a;
      r1_zeta <= bus.in_zeta;
    end
  end

  always_ff @(posedge clk) begin
    if (w_s2_free && r1_v) begin
      r2_bar  <= w_bar;
      r2_prod <= int'(r1_diff) * int'(r1_zeta);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r1_v <= 1'b0;
      r2_v <= 1'b0;
    end else begin
      if (w_in_fire) begin
        r1_v <= 1'b1;
      end else if (w_s2_free) begin
        r1_v <= 1'b0;
      end
      if (w_s2_free) begin
        r2_v <= r1_v;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r3_v <= 1'b0;
      r3_a <= '0;
      r3_b <= '0;
    end else if (w_s3_free) begin
      r3_v <= r2_v;
      if (r2_v) begin
        r3_a <= r2_bar;
        r3_b <= w_mont;
      end
    end
  end

endmodule

// File: tb/tb_gs_butterfly.sv
// Directed and streaming checks for the GS butterfly.
module tb_gs_butterfly;
  import kyber_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_pass = 0;
  int   n_total = 0;

  always #5 clk = ~clk;

  gs_butterfly_if bus ();

  gs_butterfly dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    shortint a;
    shortint b;
  } exp_t;

  function automatic shortint ref_barrett(shortint x);
    int t;
    t = (20159 * int'(x) + (1 <<< 25)) >>> 26;
    return shortint'(int'(x) - t * 3329);
  endfunction

  function automatic shortint ref_mont(int x);
    shortint t;
    t = shortint'(x * -3327);
    return shortint'((x - int'(t) * 3329) >>> 16);
  endfunction

  function automatic exp_t ref_gs(shortint a, shortint b, shortint z);
    exp_t e;
    shortint s;
    shortint d;
    s = shortint'(int'(a) + int'(b));
    d = shortint'(int'(b) - int'(a));
    e.a = ref_barrett(s);
    e.b = ref_mont(int'(d) * int'(z));
    return e;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_zeta   = '0;
    bus.out_ready = 1'b1;
  endtask

  task automatic test_reset;
    idle_inputs();
    rst_n = 1'b0;
    #12;
    n_total++;
    if (bus.out_valid !== 1'b0)
      $display("FAIL rst_valid got %b want 0", bus.out_valid);
    else n_pass++;
    n_total++;
    if (bus.out_a !== 16'sd0 || bus.out_b !== 16'sd0)
      $display("FAIL rst_data got %0d,%0d want 0,0",
               bus.out_a, bus.out_b);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    n_total++;
    if (bus.in_ready !== 1'b1)
      $display("FAIL rst_ready got %b want 1", bus.in_ready);
    else n_pass++;
  endtask

  task automatic test_latency(input shortint a, input shortint b,
                              input shortint z, input shortint ea,
                              input shortint eb, input string nm);
    int n;
    bus.out_ready = 1'b1;
    bus.in_a      = a;
    bus.in_b      = b;
    bus.in_zeta   = z;
    bus.in_valid  = 1'b1;
    #1;
    n_total++;
    if (bus.in_ready !== 1'b1)
      $display("FAIL %s_ready got %b want 1", nm, bus.in_ready);
    else n_pass++;
    tick();
    bus.in_valid = 1'b0;
    n = 1;
    while (bus.out_valid !== 1'b1 && n < 10) begin
      tick();
      n++;
    end
    n_total++;
    if (n !== 3)
      $display("FAIL %s_latency got %0d want 3", nm, n);
    else n_pass++;
    n_total++;
    if (bus.out_a !== ea || bus.out_b !== eb)
      $display("FAIL %s_data got %0d,%0d want %0d,%0d",
               nm, bus.out_a, bus.out_b, ea, eb);
    else n_pass++;
    tick();
    n_total++;
    if (bus.out_valid !== 1'b0)
      $display("FAIL %s_drain got %b want 0", nm, bus.out_valid);
    else n_pass++;
  endtask

  task automatic test_directed;
    test_latency(1, 2, 1, 3, 169, "unit");
    test_latency(0, 3329, 1, 0, 0, "q");
    test_latency(0, 5, 2285, 5, 5, "rmont");
    test_latency(-5, 0, 2285, -5, 5, "neg");
  endtask

  task automatic test_stall;
    shortint sa [4] = '{1, 0, 0, -5};
    shortint sb [4] = '{2, 3329, 5, 0};
    shortint sz [4] = '{1, 1, 2285, 2285};
    shortint ea [4] = '{3, 0, 5, -5};
    shortint eb [4] = '{169, 0, 5, 5};
    int idx = 0;
    bit acc;
    bus.out_ready = 1'b0;
    for (int c = 0; c < 6; c++) begin
      bus.in_valid = 1'b1;
      bus.in_a     = sa[idx];
      bus.in_b     = sb[idx];
      bus.in_zeta  = sz[idx];
      #1;
      acc = bus.in_ready;
      tick();
      if (acc && idx < 3) idx++;
    end
    bus.in_a    = sa[idx];
    bus.in_b    = sb[idx];
    bus.in_zeta = sz[idx];
    #1;
    n_total++;
    if (idx !== 3)
      $display("FAIL stall_accepted got %0d want 3", idx);
    else n_pass++;
    n_total++;
    if (bus.in_ready !== 1'b0)
      $display("FAIL stall_ready got %b want 0", bus.in_ready);
    else n_pass++;
    tick();
    tick();
    n_total++;
    if (bus.out_valid !== 1'b1 || bus.out_a !== 16'sd3
        || bus.out_b !== 16'sd169)
      $display("FAIL stall_hold got %b/%0d/%0d want 1/3/169",
               bus.out_valid, bus.out_a, bus.out_b);
    else n_pass++;
    bus.out_ready = 1'b1;
    #1;
    n_total++;
    if (bus.in_ready !== 1'b1)
      $display("FAIL stall_shift_ready got %b want 1", bus.in_ready);
    else n_pass++;
    for (int k = 0; k < 4; k++) begin
      n_total++;
      if (bus.out_valid !== 1'b1 || bus.out_a !== ea[k]
          || bus.out_b !== eb[k])
        $display("FAIL stall_out%0d got %b/%0d/%0d want 1/%0d/%0d",
                 k, bus.out_valid, bus.out_a, bus.out_b,
                 ea[k], eb[k]);
      else n_pass++;
      tick();
      bus.in_valid = 1'b0;
      #1;
    end
    n_total++;
    if (bus.out_valid !== 1'b0)
      $display("FAIL stall_empty got %b want 0", bus.out_valid);
    else n_pass++;
    idle_inputs();
  endtask

  task automatic test_back_to_back;
    exp_t q[$];
    exp_t e;
    int sent = 0;
    int got = 0;
    int cyc = 0;
    while (got < 100 && cyc < 3000) begin
      bus.in_valid  = (sent < 100) && ($urandom_range(0, 7) != 0);
      bus.in_a      = shortint'($urandom);
      bus.in_b      = shortint'($urandom);
      bus.in_zeta   = shortint'($urandom);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      #1;
      if (bus.in_valid && bus.in_ready) begin
        q.push_back(ref_gs(bus.in_a, bus.in_b, bus.in_zeta));
        sent++;
      end
      if (bus.out_valid && bus.out_ready) begin
        n_total++;
        if (q.size() == 0) begin
          $display("FAIL b2b_extra got %0d,%0d want none",
                   bus.out_a, bus.out_b);
        end else begin
          e = q.pop_front();
          if (bus.out_a !== e.a || bus.out_b !== e.b)
            $display("FAIL b2b_%0d got %0d,%0d want %0d,%0d",
                     got, bus.out_a, bus.out_b, e.a, e.b);
          else n_pass++;
        end
        got++;
      end
      tick();
      cyc++;
    end
    n_total++;
    if (sent !== 100 || got !== 100 || q.size() !== 0)
      $display("FAIL b2b_count got %0d/%0d left %0d want 100/100/0",
               sent, got, q.size());
    else n_pass++;
    idle_inputs();
    tick();
  endtask

  task automatic test_reset_inflight;
    int stale = 0;
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_a      = 1;
    bus.in_b      = 2;
    bus.in_zeta   = 1;
    tick();
    bus.in_a    = 0;
    bus.in_b    = 5;
    bus.in_zeta = 2285;
    tick();
    bus.in_valid = 1'b0;
    tick();
    n_total++;
    if (bus.out_valid !== 1'b1)
      $display("FAIL rsti_pre got %b want 1", bus.out_valid);
    else n_pass++;
    #1;
    rst_n = 1'b0;
    #1;
    n_total++;
    if (bus.out_valid !== 1'b0 || bus.out_a !== 16'sd0
        || bus.out_b !== 16'sd0)
      $display("FAIL rsti_async got %b/%0d/%0d want 0/0/0",
               bus.out_valid, bus.out_a, bus.out_b);
    else n_pass++;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (bus.out_valid !== 1'b0) stale++;
    end
    n_total++;
    if (stale !== 0)
      $display("FAIL rsti_stale got %0d want 0", stale);
    else n_pass++;
    test_latency(-5, 0, 2285, -5, 5, "rsti_next");
  endtask

  initial begin
    test_reset();
    test_directed();
    test_stall();
    test_back_to_back();
    test_reset_inflight();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/gs_butterfly.md
Name: gs_butterfly

Overview:
- Pipelined Gentleman-Sande (inverse-NTT) butterfly for Kyber (q = 3329); counterpart of the forward Cooley-Tukey path built around the Montgomery multiplier.
- Per accepted pair it produces two outputs:
  - out_a = barrett_reduce(a + b)
  - out_b = fqmul(zeta, b - a)
- Sits between the coefficient RAM read port and write-back in the inverse-NTT datapath; valid/ready streaming on both sides.

Parameters:
- KYBER_Q, 3329, modulus.
- QINV, -3327, q^-1 mod 2^16 (signed), Montgomery constant.
- BARRETT_V, 20159, round(2^26 / q).
- DATA_W, 16, coefficient width (signed); fixed, not for reuse at other widths.

Ports:
- clk  input  1  clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  input pair + zeta valid.
- in_ready  output  1  block can accept this cycle.
- in_a  input  16  signed coefficient r[j].
- in_b  input  16  signed coefficient r[j+len].
- in_zeta  input  16  signed twiddle, Montgomery form.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts.
- out_a  output  16  signed, new r[j].
- out_b  output  16  signed, new r[j+len].

Behaviour:
- Reset: one clock; asynchronous, active-low (rst_n).
  - Asserting rst_n low clears all stage valid bits immediately; out_valid=0, out_a=0, out_b=0.
  - in_ready is 1 from the first cycle after release.
  - Reset mid-operation discards all in-flight data; no partial outputs.
- Pipeline: 3 register stages S1, S2, S3, each with its own valid bit. Latency 3 cycles from input handshake to out_valid with out_ready held high.
  - S1: capture in_a, in_b, in_zeta. Compute:
    - sum = (a + b) truncated to 16 bits
    - diff = (b - a) truncated to 16 bits
    - Wrap mod 2^16 matches int16 store semantics.
  - S2: store Barrett result and 32-bit signed prod = diff * zeta.
    - Barrett: t = (BARRETT_V * sum + 2^25) >>> 26 (arithmetic shift); result = sum - t*q, low 16 bits.
  - S3: Montgomery reduction.
    - m = int16(prod[15:0] * QINV)
    - out_b = (prod - m*q)[31:16]
    - out_a is the S2 Barrett value passed through.
- Handshake:
  - Transfer occurs on valid && ready at the clock edge.
  - Stage k advances when stage k+1 is empty or advancing; S3 advances on out_ready.
  - in_ready = !S1.valid || S1 advances. This is a combinational ready chain; there is no bubble.
  - Sustained throughput is 1 per cycle.
- Stall:
  - With out_ready=0, out_a, out_b and out_valid hold stable.
  - At most 3 pairs are resident; in_ready=0 once all stages are full.
  - Simultaneous out accept and in accept while full: the pipeline shifts and in_ready stays 1.
- out_valid must not depend combinationally on out_ready.
- Data registers need no reset (only valids); output registers are reset to 0 for determinism.

Decomposition:
- Package kyber_pkg: KYBER_Q, QINV, BARRETT_V, coefficient typedef (signed 16-bit).
- Sub-modules:
  - barrett_reduce: combinational, 16 in, 16 out.
  - The Montgomery reduce is inlined in S3 (or reuses the existing fqmul logic split at its product boundary).
  - No other sub-modules.

Test Plan:
- a=1, b=2, zeta=1 -> out_a=3, out_b=169 (2^-16 mod q), out_valid exactly 3 cycles after accept.
- a=0, b=3329, zeta=1 -> out_a=0, out_b=0.
- a=0, b=5, zeta=2285 (R mod q) -> out_a=5, out_b=5; a=-5, b=0, zeta=2285 -> out_a=-5, out_b=5.
- out_ready=0, in_valid=1 with 4 distinct pairs -> exactly 3 accepted, in_ready=0, first result held stable; release out_ready -> 4 results in order on consecutive cycles.
- Back-to-back 100 random pairs with random out_ready toggling -> results match C reference (invntt butterfly), no drops or duplicates.
- rst_n pulsed low with 2 pairs in flight -> out_valid=0 asynchronously, outputs 0, no stale result after release; next pair returns correctly at latency 3.
